// File: rtl/sfp_link_monitor.sv
// N-channel SFP+ link supervisor: sync, debounce, presence/TX-disable, flap count, LEDs.
// Optional per-channel activity blink on the green LED when LINK_ACTIVITY_BLINK_EN is defined.
module sfp_link_chan #(
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int CNT_WIDTH       = 16,
  parameter int BLINK_CYCLES    = 3125000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lock_raw,
  input  logic                 npres_raw,
  input  logic                 los_raw,
  input  logic                 act,
  input  logic                 clear_counts,
  output logic                 link_up_d,
  output logic                 link_up_q,
  output logic [CNT_WIDTH-1:0] flap_q,
  output logic [1:0]           led_q,
  output logic                 tx_dis_q
);
  localparam int QW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {ABSENT, DOWN, QUAL, UP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           lock_sync_q, lock_sync_d;
  logic [1:0]           npres_sync_q, npres_sync_d;
  logic [1:0]           los_sync_q, los_sync_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic [CNT_WIDTH-1:0] flap_d;
  logic [1:0]           led_d;
  logic                 tx_dis_d;
  logic                 flap_ev;
  logic                 clean;
  logic                 blank;

  always_comb begin
    lock_sync_d  = {lock_sync_q[0], lock_raw};
    npres_sync_d = {npres_sync_q[0], npres_raw};
    los_sync_d   = {los_sync_q[0], los_raw};
  end

  assign clean = lock_sync_q[1] & ~los_sync_q[1];

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    flap_ev = 1'b0;
    if (npres_sync_q[1]) begin
      state_d = ABSENT;
    end else begin
      case (state_q)
        ABSENT: state_d = DOWN;
        DOWN: if (clean) begin
          state_d = QUAL;
          qcnt_d  = QW'(DEBOUNCE_CYCLES - 1);
        end
        QUAL: begin
          if (!clean)              state_d = DOWN;
          else if (qcnt_q == '0)   state_d = UP;
          else                     qcnt_d  = qcnt_q - 1'b1;
        end
        UP: if (!clean) begin
          state_d = DOWN;
          flap_ev = 1'b1;
        end
        default: state_d = ABSENT;
      endcase
    end
  end

  // Clear wins over a same-cycle flap; the count sticks at all-ones.
  always_comb begin
    flap_d = flap_q;
    if (clear_counts)                   flap_d = '0;
    else if (flap_ev && flap_q != '1)   flap_d = flap_q + 1'b1;
  end

`ifdef LINK_ACTIVITY_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_CYCLES);
  logic [BW-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = blink_q;
    if (state_d != UP)                 blink_d = '0;
    else if (blink_q != '0)            blink_d = blink_q - 1'b1;
    else if (act && state_q == UP)     blink_d = BW'(2 * BLINK_CYCLES - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end

  // First half of the blink period blanks the green LED.
  assign blank = (blink_q >= BW'(BLINK_CYCLES));
`else
  logic unused_act;
  assign unused_act = act;
  assign blank      = 1'b0;
`endif

  assign link_up_d = (state_q == UP);

  always_comb begin
    tx_dis_d = (state_q == ABSENT);
    led_d[1] = (state_q == DOWN) || (state_q == QUAL);
    led_d[0] = link_up_d & ~blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync_q  <= 2'b00;
      npres_sync_q <= 2'b11;
      los_sync_q   <= 2'b11;
      state_q      <= ABSENT;
      qcnt_q       <= '0;
      flap_q       <= '0;
      link_up_q    <= 1'b0;
      led_q        <= 2'b00;
      tx_dis_q     <= 1'b1;
    end else begin
      lock_sync_q  <= lock_sync_d;
      npres_sync_q <= npres_sync_d;
      los_sync_q   <= los_sync_d;
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      flap_q       <= flap_d;
      link_up_q    <= link_up_d;
      led_q        <= led_d;
      tx_dis_q     <= tx_dis_d;
    end
  end
endmodule

module sfp_link_monitor #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 156250,
  parameter int CNT_WIDTH       = 16,
  parameter int BLINK_CYCLES    = 3125000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           rx_block_lock,
  input  logic [CHANNELS-1:0]           sfp_npres,
  input  logic [CHANNELS-1:0]           sfp_los,
  input  logic [CHANNELS-1:0]           rx_activity,
  input  logic                          clear_counts,
  output logic [CHANNELS-1:0]           link_up,
  output logic                          link_change,
  output logic [CHANNELS*CNT_WIDTH-1:0] flap_count,
  output logic [2*CHANNELS-1:0]         sfp_led,
  output logic [CHANNELS-1:0]           sfp_tx_disable
);
  logic [CHANNELS-1:0] up_d;
  logic                link_change_q, link_change_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sfp_link_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .BLINK_CYCLES   (BLINK_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .lock_raw    (rx_block_lock[i]),
      .npres_raw   (sfp_npres[i]),
      .los_raw     (sfp_los[i]),
      .act         (rx_activity[i]),
      .clear_counts(clear_counts),
      .link_up_d   (up_d[i]),
      .link_up_q   (link_up[i]),
      .flap_q      (flap_count[i*CNT_WIDTH +: CNT_WIDTH]),
      .led_q       (sfp_led[2*i +: 2]),
      .tx_dis_q    (sfp_tx_disable[i])
    );
  end

  // Any channel's link_up about to toggle gives one shared pulse.
  assign link_change_d = |(up_d ^ link_up);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) link_change_q <= 1'b0;
    else     link_change_q <= link_change_d;
  end

  assign link_change = link_change_q;
endmodule

// File: tb/tb_sfp_link_monitor.sv
// Directed bench for sfp_link_monitor: 4 channels, 16-clock debounce, 2-bit flap counters.
module tb_sfp_link_monitor;
  localparam int CH  = 4;
  localparam int DEB = 16;
  localparam int CW  = 2;
  localparam int BL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   lock, npres, los, act;
  logic            clr;
  logic [CH-1:0]   link_up;
  logic            link_change;
  logic [CH*CW-1:0] flap_count;
  logic [2*CH-1:0] sfp_led;
  logic [CH-1:0]   sfp_tx_disable;

  int errors = 0;
  int checks = 0;
  int lc_cnt = 0;

  sfp_link_monitor #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (CW),
    .BLINK_CYCLES   (BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_block_lock (lock),
    .sfp_npres     (npres),
    .sfp_los       (los),
    .rx_activity   (act),
    .clear_counts  (clr),
    .link_up       (link_up),
    .link_change   (link_change),
    .flap_count    (flap_count),
    .sfp_led       (sfp_led),
    .sfp_tx_disable(sfp_tx_disable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] npres, lock, los;
    logic       clr;
    logic [7:0] cyc;
    logic [3:0] exp_lu, exp_txd;
    logic [7:0] exp_led, exp_flap;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (link_change === 1'b1) lc_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic am;
    logic exp_g;

    // Inputs held: npres, lock, los, clr, cycles -> link_up, tx_disable, led, flap
    tbl[0] = '{4'hF, 4'h0, 4'hF, 1'b0, 8'd5,  4'h0, 4'hF, 8'h00, 8'h00};
    tbl[1] = '{4'h0, 4'h0, 4'hF, 1'b0, 8'd5,  4'h0, 4'h0, 8'hAA, 8'h00};
    tbl[2] = '{4'h0, 4'hF, 4'h0, 1'b0, 8'd25, 4'hF, 4'h0, 8'h55, 8'h00};
    tbl[3] = '{4'h0, 4'hE, 4'h0, 1'b0, 8'd5,  4'hE, 4'h0, 8'h56, 8'h01};
    tbl[4] = '{4'h0, 4'hF, 4'h0, 1'b0, 8'd25, 4'hF, 4'h0, 8'h55, 8'h01};
    tbl[5] = '{4'h0, 4'hF, 4'h4, 1'b0, 8'd5,  4'hB, 4'h0, 8'h65, 8'h11};
    tbl[6] = '{4'h8, 4'hF, 4'h0, 1'b0, 8'd25, 4'h7, 4'h8, 8'h15, 8'h11};
    tbl[7] = '{4'h0, 4'h7, 4'h0, 1'b0, 8'd5,  4'h7, 4'h0, 8'h95, 8'h11};
    tbl[8] = '{4'h0, 4'h7, 4'h0, 1'b1, 8'd2,  4'h7, 4'h0, 8'h95, 8'h00};
    tbl[9] = '{4'h0, 4'hF, 4'h0, 1'b0, 8'd25, 4'hF, 4'h0, 8'h55, 8'h00};

    rst = 1'b1; npres = 4'hF; lock = 4'h0; los = 4'hF; act = 4'h0; clr = 1'b0;
    run(3);
    chk("rst_link_up", 32'(link_up), 0);
    chk("rst_link_change", 32'(link_change), 0);
    chk("rst_flap", 32'(flap_count), 0);
    chk("rst_led", 32'(sfp_led), 0);
    chk("rst_txdis", 32'(sfp_tx_disable), 32'hF);
    rst = 1'b0;
    run(3);

    // Presence then clean lock on ch0: exact latencies
    npres[0] = 1'b0;
    k = -1;
    for (int j = 0; j < 20; j++) begin
      step();
      if (!sfp_tx_disable[0]) begin k = j; break; end
    end
    chk("txdis_fall_latency", k, 3);
    chk("amber_down", 32'(sfp_led[1:0]), 2);
    run(2);
    lock[0] = 1'b1; los[0] = 1'b0;
    lc_cnt = 0; am = 1'b0; k = -1;
    for (int j = 0; j < 40; j++) begin
      step();
      if (j == 10) am = sfp_led[1];
      if (link_up[0]) begin k = j; break; end
    end
    chk("link_up_rise_latency", k, DEB + 3);
    chk("amber_qual", 32'(am), 1);
    chk("lc_at_rise", 32'(link_change), 1);
    chk("lc_count_rise", lc_cnt, 1);
    step();
    chk("led_up", 32'(sfp_led[1:0]), 1);
    chk("lc_one_cycle", 32'(link_change), 0);

    // ch1: one-clock lock dropout mid-qualification restarts the debounce
    npres[1] = 1'b0;
    run(5);
    lock[1] = 1'b1; los[1] = 1'b0;
    run(12);
    lock[1] = 1'b0;
    step();
    lock[1] = 1'b1;
    k = -1;
    for (int j = 0; j < 40; j++) begin
      step();
      if (link_up[1]) begin k = j; break; end
    end
    chk("requal_latency", k, DEB + 3);
    chk("glitch_no_flap", 32'(flap_count), 0);

    // ch0 flaps: three counted, then saturation
    lc_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      lock[0] = 1'b0; run(6);
      lock[0] = 1'b1; run(25);
    end
    chk("flap_count_3", 32'(flap_count[1:0]), 3);
    chk("lc_pulses_6", lc_cnt, 6);
    chk("both_up", 32'(link_up), 32'h3);
    for (int f = 0; f < 2; f++) begin
      lock[0] = 1'b0; run(6);
      lock[0] = 1'b1; run(25);
    end
    chk("flap_saturated", 32'(flap_count[1:0]), 3);

    npres[0] = 1'b1;
    run(6);
    chk("absent_txdis", 32'(sfp_tx_disable[0]), 1);
    chk("absent_link_up", 32'(link_up[0]), 0);
    chk("absent_led", 32'(sfp_led[1:0]), 0);
    chk("absent_no_flap", 32'(flap_count[1:0]), 3);
    npres[0] = 1'b0;
    run(30);
    chk("reinsert_up", 32'(link_up[0]), 1);

    // clear_counts lands on the same clock as a flap increment
    lock[0] = 1'b0;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    run(3);
    chk("clear_beats_flap", 32'(flap_count[1:0]), 0);
    chk("clear_link_down", 32'(link_up[0]), 0);
    lock[0] = 1'b1;
    run(25);

    // All up, then ch1 and ch3 drop together
    npres = 4'h0; lock = 4'hF; los = 4'h0;
    run(30);
    chk("all_up", 32'(link_up), 32'hF);
    lc_cnt = 0;
    lock = 4'b0101;
    run(8);
    chk("dual_drop_link_up", 32'(link_up), 32'h5);
    chk("dual_drop_one_pulse", lc_cnt, 1);
    chk("dual_drop_flaps", 32'(flap_count), 32'h44);
    lock = 4'hF;
    run(25);

    // Activity blink on ch0; second pulse at clock 2 must be ignored
    act[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (j == 0) act[0] = 1'b0;
      if (j == 1) act[0] = 1'b1;
      if (j == 2) act[0] = 1'b0;
`ifdef LINK_ACTIVITY_BLINK_EN
      exp_g = (j == 0 || j >= 5) ? 1'b1 : 1'b0;
`else
      exp_g = 1'b1;
`endif
      chk($sformatf("green_blink_%0d", j), 32'(sfp_led[0]), 32'(exp_g));
    end

    // Asynchronous reset mid-blink
    act[0] = 1'b1;
    step();
    act[0] = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(sfp_led), 0);
    chk("async_rst_txdis", 32'(sfp_tx_disable), 32'hF);
    chk("async_rst_link_up", 32'(link_up), 0);
    chk("async_rst_flap", 32'(flap_count), 0);
    run(2);
    rst = 1'b0;
    step();

    for (int v = 0; v < 10; v++) begin
      npres = tbl[v].npres;
      lock  = tbl[v].lock;
      los   = tbl[v].los;
      clr   = tbl[v].clr;
      run(int'(tbl[v].cyc));
      chk($sformatf("vec%0d_link_up", v), 32'(link_up), 32'(tbl[v].exp_lu));
      chk($sformatf("vec%0d_txdis", v), 32'(sfp_tx_disable), 32'(tbl[v].exp_txd));
      chk($sformatf("vec%0d_led", v), 32'(sfp_led), 32'(tbl[v].exp_led));
      chk($sformatf("vec%0d_flap", v), 32'(flap_count), 32'(tbl[v].exp_flap));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sfp_link_monitor.md
Name: sfp_link_monitor

Overview:
Parametrised N-channel SFP+ link supervisor between the 10G PHY wrappers and the board GPIO. It replaces direct LED-from-block-lock wiring with synchronised, debounced link qualification, module presence handling, TX-disable control, link-flap counting and LED drive. It runs in the 156.25 MHz core clock domain; all raw status inputs are treated as asynchronous.

Parameters:
CHANNELS, 2, number of SFP channels monitored (1..8)
DEBOUNCE_CYCLES, 156250, clocks block lock must stay clean before link-up (>=2; 1 ms at 156.25 MHz)
CNT_WIDTH, 16, width of each per-channel flap counter
BLINK_CYCLES, 3125000, half-period of the activity blink in clocks (>=1)

Ports:
clk  in  1  core clock, 156.25 MHz
rst  in  1  asynchronous active-high reset
rx_block_lock  in  CHANNELS  per-channel PHY block lock, async
sfp_npres  in  CHANNELS  module-not-present, active-high, async
sfp_los  in  CHANNELS  loss of signal, active-high, async
rx_activity  in  CHANNELS  one-cycle frame-received pulse, clk domain
clear_counts  in  1  synchronous clear of all flap counters
link_up  out  CHANNELS  qualified link status
link_change  out  1  one-cycle pulse on any link_up edge
flap_count  out  CHANNELS*CNT_WIDTH  per-channel UP->DOWN count, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
sfp_led  out  2*CHANNELS  [2i]=green link, [2i+1]=amber present-no-link
sfp_tx_disable  out  CHANNELS  SFP TX disable, 1 = disabled

Behaviour:
- Reset: rst is asynchronous and active-high; all flops clear on its assertion. Outputs during/after reset: link_up=0, link_change=0, flap_count=0, sfp_led=0, sfp_tx_disable=all 1.
- Reset values of the synchroniser flops: npres=1, los=1, lock=0.
- Sync: 2-flop synchroniser per raw input. The synced value is valid 2 clocks after capture.
- Per-channel FSM: ABSENT, DOWN, QUAL, UP (reset state ABSENT).
- Any state: synced npres=1 -> ABSENT next clock. This has highest priority.
- ABSENT: tx_disable=1. When npres=0 -> DOWN.
- DOWN: tx_disable=0. When lock=1 and los=0 -> QUAL, qualification counter loaded with DEBOUNCE_CYCLES-1.
- QUAL: counter decrements each clock.
  - lock=0 or los=1 -> DOWN.
  - counter==0 with lock clean -> UP.
- UP: when lock=0 or los=1 -> DOWN, and flap counter +1.
  - UP->ABSENT does not count as a flap.
- Latency: a clean lock/los edge captured at clock t gives link_up=1 at t+DEBOUNCE_CYCLES+3. Loss of lock gives link_up=0 at t+3.
- link_up is registered: 1 exactly in state UP.
- link_change is registered and pulses 1 clock in the same cycle link_up changes on any channel. Simultaneous changes on several channels produce a single pulse.
- Flap counter saturates at all-ones; it never wraps.
- clear_counts has priority over an increment in the same clock; the result is 0.
- sfp_led[2i+1]=1 in DOWN or QUAL; 0 in ABSENT and UP.
- sfp_led[2i]=link_up[i], modified by the optional feature below.
- Channels are fully independent apart from link_change and clear_counts.

Optional Feature:
LINK_ACTIVITY_BLINK_EN
- Defined: per-channel blink timer.
  - An rx_activity pulse while UP and timer==0 loads 2*BLINK_CYCLES-1. The timer decrements to 0.
  - Green LED is 0 while timer>=BLINK_CYCLES, and equals link_up otherwise.
  - Pulses while timer!=0 are ignored.
  - Leaving UP clears the timer.
- Undefined: no timer logic. rx_activity is unused, and green LED = link_up.

Test Plan:
1. DEBOUNCE_CYCLES=16, ch0: npres 1->0, then lock=1, los=0 -> tx_disable[0] falls 3 clocks after npres; link_up[0] rises 19 clocks after lock captured; one link_change pulse; amber 1 during QUAL, 0 in UP.
2. In QUAL, drop lock for 1 clock at count 5 -> return to DOWN; link_up stays 0; re-qualification takes a full 16+ clocks; flap_count[0]=0.
3. From UP, toggle lock low 3 times (requalifying each time) -> flap_count[0]=3, 6 link_change pulses; npres=1 from UP -> ABSENT, tx_disable=1, flap_count unchanged.
4. CNT_WIDTH=2: 5 flaps -> count saturates at 3; assert clear_counts in the same clock as the next flap -> count=0.
5. CHANNELS=4: ch1 and ch3 lose lock in the same clock -> both link_up fall together, exactly one link_change pulse, other channels unaffected.
6. LINK_ACTIVITY_BLINK_EN defined, BLINK_CYCLES=4, UP: rx_activity pulse -> green 0 for 4 clocks then 1 for 4; a second pulse at clock 2 is ignored. Repeat with the macro undefined -> green stays 1. Assert rst mid-blink -> all LEDs 0 and tx_disable all 1 immediately.
